quiz_scoreboard: RTL and testbench
==================================

QUIZ_SCOREBOARD -- requirements
Module: quiz_scoreboard

Interface
REQ-001 The block SHALL have parameter N_PLAYERS, default 4, meaning number of contestants (2..8).
REQ-002 The block SHALL have parameter SCORE_W, default 4, meaning per-player score width.
REQ-003 The block SHALL have parameter PROB_W, default 3, meaning problem counter width.
REQ-004 The block SHALL have parameter NUM_PROBLEMS, default 7, meaning problems per game (1..2**PROB_W-1).
REQ-005 The block SHALL have parameter POINTS, default 1, meaning points awarded per correct answer (1..2**SCORE_W-1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-007 The block SHALL have port greset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port ready, input, 1 bit: answer-commit request, level input, rising-edge detected internally.
REQ-009 The block SHALL have port check, input, N_PLAYERS bits: bit i high means player i answered correctly.
REQ-010 The block SHALL have port scores, output, N_PLAYERS*SCORE_W bits: player i at bits [i*SCORE_W +: SCORE_W].
REQ-011 The block SHALL have port problem, output, PROB_W bits: number of committed problems.
REQ-012 The block SHALL have port reset, output, 1 bit: one-cycle round-clear pulse to the answer checkers.
REQ-013 The block SHALL have port game_over, output, 1 bit: high in OVER state.
REQ-014 The block SHALL have port winner, output, N_PLAYERS bits: multi-hot set of top scorers, zero unless game_over.
REQ-015 The block SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-016 The FSM SHALL have states IDLE=0, PLAY=1, OVER=2; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-017 IDLE SHALL move to PLAY on the first clock edge where ready is sampled low, so a ready held high through reset never commits.
REQ-018 The edge SHALL be computed as commit = ready AND NOT ready_q, where ready_q is ready registered each cycle in all states.
REQ-019 In PLAY, on a clock edge with commit=1, each player i with check[i]=1 SHALL gain POINTS, and scores SHALL be visible the next cycle (1-cycle latency).
REQ-020 Score addition SHALL saturate at 2**SCORE_W-1 and never wrap.
REQ-021 check SHALL be sampled only on the commit edge; check changes at all other times SHALL have no effect.
REQ-022 On the same commit edge, problem SHALL increment by 1, and reset SHALL be high for exactly the following cycle.
REQ-023 A ready held high for many cycles SHALL produce exactly one commit; re-arming SHALL require ready to go low for at least one cycle.
REQ-024 A commit that makes problem equal NUM_PROBLEMS SHALL move the FSM to OVER on that edge; that commit still scores and still pulses reset.
REQ-025 In OVER, ready and check SHALL be ignored, and scores, problem and reset=0 SHALL hold until greset.
REQ-026 winner SHALL be combinational from the registered scores: bit i is set when score i equals the maximum over all players; ties set every tied bit; the all-zero-scores case sets all bits.
REQ-027 In IDLE and OVER, commit SHALL never increment problem or scores.

Reset
REQ-028 While greset is high, the block SHALL asynchronously force: scores=0, problem=0, reset=0, game_over=0, winner=0, ready_q=0, state=IDLE.
REQ-029 Asserting greset mid-game, including during a reset pulse, SHALL abort the game with no partial score update.
REQ-030 Reset deassertion SHALL be synchronised externally; the block's first active edge after deassertion SHALL follow REQ-017.

Structure
REQ-031 Package quiz_pkg SHALL hold the state encoding constants and the parameter defaults.
REQ-032 The winner logic SHALL be one sub-module, quiz_max_tree (inputs: packed scores; output: multi-hot max mask), parametrised by N_PLAYERS and SCORE_W.
REQ-033 All state SHALL sit in one clk/greset process, with no latches and no derived clocks.

Verification
REQ-034 Scenario reset/IDLE gating: greset with ready=1 held, then release -> no commit until ready falls; problem=0, state=IDLE then PLAY.
REQ-035 Scenario basic commit: check=4'b0101, ready rises once -> next cycle scores P0=1, P2=1, problem=1, reset high exactly one cycle.
REQ-036 Scenario level hold: ready held high for 10 cycles -> problem increments once only.
REQ-037 Scenario saturation: SCORE_W=2, POINTS=3, check[0]=1 for two commits -> P0 stays at 3.
REQ-038 Scenario game end: 7 commits where P1 and P3 each score 5 -> state=OVER after the 7th, game_over=1, winner=4'b1010, and an 8th ready edge changes nothing.
REQ-039 Scenario mid-game abort: greset asserted asynchronously between edges at problem=3 -> all outputs zero immediately, state=IDLE.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared state encoding and parameter defaults for the quiz scoreboard.
package quiz_pkg;

  localparam int unsigned N_PLAYERS_DEF    = 4;
  localparam int unsigned SCORE_W_DEF      = 4;
  localparam int unsigned PROB_W_DEF       = 3;
  localparam int unsigned NUM_PROBLEMS_DEF = 7;
  localparam int unsigned POINTS_DEF       = 1;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

endpackage

// File: rtl/quiz_max_tree.sv
// Multi-hot mask of every player whose score equals the highest score.
module quiz_max_tree
  import quiz_pkg::*;
#(
  parameter int unsigned N_PLAYERS = N_PLAYERS_DEF,
  parameter int unsigned SCORE_W   = SCORE_W_DEF
) (
  input  logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [N_PLAYERS-1:0]         max_mask
);

  logic [SCORE_W-1:0] max_c;

  // Running maximum across all players
  always_comb begin
    max_c = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (scores[i*SCORE_W +: SCORE_W] > max_c) begin
        max_c = scores[i*SCORE_W +: SCORE_W];
      end
    end
  end

  // Flag every player reaching the maximum; ties (including all-zero) set each bit
  always_comb begin
    max_mask = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      max_mask[i] = (scores[i*SCORE_W +: SCORE_W] == max_c);
    end
  end

endmodule

// File: rtl/quiz_scoreboard.sv
// Quiz game scoreboard: commits answers on ready rising edges, keeps saturating
// per-player scores and a problem count, and reports the winners once the game ends.
module quiz_scoreboard
  import quiz_pkg::*;
#(
  parameter int unsigned N_PLAYERS    = N_PLAYERS_DEF,
  parameter int unsigned SCORE_W      = SCORE_W_DEF,
  parameter int unsigned PROB_W       = PROB_W_DEF,
  parameter int unsigned NUM_PROBLEMS = NUM_PROBLEMS_DEF,
  parameter int unsigned POINTS       = POINTS_DEF
) (
  input  logic                         clk,
  input  logic                         greset,
  input  logic                         ready,
  input  logic [N_PLAYERS-1:0]         check,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [PROB_W-1:0]            problem,
  output logic                         reset,
  output logic                         game_over,
  output logic [N_PLAYERS-1:0]         winner,
  output logic [STATE_W-1:0]           state
);

  state_e                         state_q,   state_d;
  logic                           ready_q,   ready_d;
  logic [N_PLAYERS*SCORE_W-1:0]   scores_q,  scores_d;
  logic [PROB_W-1:0]              problem_q, problem_d;
  logic                           reset_q,   reset_d;
  logic                           commit_c;
  logic [N_PLAYERS-1:0]           max_mask;

  // Add POINTS to one score, clamping at all-ones instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(POINTS);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // All state registers; greset clears everything asynchronously
  always_ff @(posedge clk or posedge greset) begin
    if (greset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      scores_q  <= '0;
      problem_q <= '0;
      reset_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      scores_q  <= scores_d;
      problem_q <= problem_d;
      reset_q   <= reset_d;
    end
  end

  // Next-state: IDLE waits for ready low, PLAY scores each commit, OVER freezes
  always_comb begin
    state_d   = state_q;
    ready_d   = ready;
    scores_d  = scores_q;
    problem_d = problem_q;
    reset_d   = 1'b0;
    commit_c  = ready & ~ready_q;
    case (state_q)
      ST_IDLE: begin
        if (!ready) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (commit_c) begin
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (check[i]) begin
              scores_d[i*SCORE_W +: SCORE_W] = sat_add(scores_q[i*SCORE_W +: SCORE_W]);
            end
          end
          problem_d = problem_q + PROB_W'(1);
          reset_d   = 1'b1;
          if (problem_d == PROB_W'(NUM_PROBLEMS)) begin
            state_d = ST_OVER;
          end
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  quiz_max_tree #(
    .N_PLAYERS (N_PLAYERS),
    .SCORE_W   (SCORE_W)
  ) u_max_tree (
    .scores   (scores_q),
    .max_mask (max_mask)
  );

  assign scores    = scores_q;
  assign problem   = problem_q;
  assign reset     = reset_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);
  assign winner    = game_over ? max_mask : '0;

endmodule

// File: tb/tb_quiz_scoreboard.sv
// Self-checking bench for quiz_scoreboard: a behavioural game model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_quiz_scoreboard;

  localparam int unsigned NP    = 4;
  localparam int unsigned SW    = 4;
  localparam int unsigned PW    = 3;
  localparam int unsigned NPROB = 7;
  localparam int unsigned PTS   = 1;
  localparam int unsigned SW_S  = 2;
  localparam int unsigned PTS_S = 3;
  localparam int          SMAX  = (1 << SW) - 1;

  logic clk = 1'b0;
  logic greset, ready, ready_s;
  logic [NP-1:0] check, check_s;

  logic [NP*SW-1:0]   scores;
  logic [PW-1:0]      problem;
  logic               reset_o, game_over;
  logic [NP-1:0]      winner;
  logic [1:0]         state;

  logic [NP*SW_S-1:0] scores_s;
  logic [PW-1:0]      problem_s;
  logic               reset_s, game_over_s;
  logic [NP-1:0]      winner_s;
  logic [1:0]         state_s;

  always #5 clk = ~clk;

  quiz_scoreboard #(
    .N_PLAYERS(NP), .SCORE_W(SW), .PROB_W(PW), .NUM_PROBLEMS(NPROB), .POINTS(PTS)
  ) dut (
    .clk(clk), .greset(greset), .ready(ready), .check(check),
    .scores(scores), .problem(problem), .reset(reset_o),
    .game_over(game_over), .winner(winner), .state(state)
  );

  quiz_scoreboard #(
    .N_PLAYERS(NP), .SCORE_W(SW_S), .PROB_W(PW), .NUM_PROBLEMS(NPROB), .POINTS(PTS_S)
  ) dut_sat (
    .clk(clk), .greset(greset), .ready(ready_s), .check(check_s),
    .scores(scores_s), .problem(problem_s), .reset(reset_s),
    .game_over(game_over_s), .winner(winner_s), .state(state_s)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  // phase: 0 waiting for ready low, 1 game running, 2 game finished
  int m_score[NP];
  int m_prob;
  int m_phase;
  bit m_pulse;
  bit m_rprev;
  bit m_rose;

  task automatic model_step();
    if (greset) begin
      foreach (m_score[i]) m_score[i] = 0;
      m_prob  = 0;
      m_phase = 0;
      m_pulse = 1'b0;
      m_rprev = 1'b0;
    end else begin
      m_rose  = ready && !m_rprev;
      m_rprev = ready;
      m_pulse = 1'b0;
      if (m_phase == 0) begin
        if (!ready) m_phase = 1;
      end else if (m_phase == 1 && m_rose) begin
        foreach (m_score[i]) begin
          if (check[i]) m_score[i] = (m_score[i] + PTS > SMAX) ? SMAX : m_score[i] + PTS;
        end
        m_prob  = m_prob + 1;
        m_pulse = 1'b1;
        if (m_prob == NPROB) m_phase = 2;
      end
    end
  endtask

  function automatic logic [NP*SW-1:0] exp_scores();
    logic [NP*SW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*SW +: SW] = SW'(m_score[i]);
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_winner();
    logic [NP-1:0] w;
    int mx;
    mx = 0;
    w  = '0;
    foreach (m_score[i]) if (m_score[i] > mx) mx = m_score[i];
    if (m_phase == 2) begin
      for (int i = 0; i < NP; i++) w[i] = (m_score[i] == mx);
    end
    return w;
  endfunction

  initial forever begin
    @(posedge clk or posedge greset);
    model_step();
  end

  // Per-cycle comparison of the main DUT against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      expect_eq("cyc_scores",    32'(scores),    32'(exp_scores()));
      expect_eq("cyc_problem",   32'(problem),   32'(m_prob));
      expect_eq("cyc_reset",     32'(reset_o),   32'(m_pulse));
      expect_eq("cyc_state",     32'(state),     32'(m_phase));
      expect_eq("cyc_game_over", 32'(game_over), 32'(m_phase == 2));
      expect_eq("cyc_winner",    32'(winner),    32'(exp_winner()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Raise ready for one edge with the given answers, then drop it and scramble check
  task automatic pulse_ready(input logic [NP-1:0] chk);
    check = chk;
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check = ~chk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    greset  = 1'b0;
    ready   = 1'b1;
    ready_s = 1'b0;
    check   = '0;
    check_s = '0;
    #1 greset = 1'b1;
    #1 cmp_en = 1'b1;

    // Reset with ready held high: nothing commits until ready falls
    step(3);
    expect_eq("rst_state",   32'(state),   32'd0);
    expect_eq("rst_problem", 32'(problem), 32'd0);
    expect_eq("rst_scores",  32'(scores),  32'd0);
    expect_eq("rst_winner",  32'(winner),  32'd0);
    greset = 1'b0;
    step(4);
    expect_eq("idle_hold_state",   32'(state),   32'd0);
    expect_eq("idle_hold_problem", 32'(problem), 32'd0);
    ready = 1'b0;
    step(1);
    expect_eq("idle_to_play", 32'(state), 32'd1);

    // Basic commit
    pulse_ready(4'b0101);
    expect_eq("basic_scores",  32'(scores),  32'h0101);
    expect_eq("basic_problem", 32'(problem), 32'd1);
    expect_eq("basic_reset",   32'(reset_o), 32'd1);
    step(1);
    expect_eq("basic_reset_end", 32'(reset_o), 32'd0);

    // Level hold: one commit only
    check = 4'b1111;
    ready = 1'b1;
    step(10);
    expect_eq("hold_problem", 32'(problem), 32'd2);
    expect_eq("hold_scores",  32'(scores),  32'h1212);
    ready = 1'b0;
    step(1);

    // Mid-game abort at problem 3, during the reset pulse
    pulse_ready(4'b0010);
    expect_eq("pre_abort_problem", 32'(problem), 32'd3);
    expect_eq("pre_abort_scores",  32'(scores),  32'h1222);
    #1 greset = 1'b1;
    #1;
    expect_eq("abort_scores",  32'(scores),    32'd0);
    expect_eq("abort_problem", 32'(problem),   32'd0);
    expect_eq("abort_reset",   32'(reset_o),   32'd0);
    expect_eq("abort_state",   32'(state),     32'd0);
    expect_eq("abort_over",    32'(game_over), 32'd0);
    step(2);
    greset = 1'b0;
    step(1);

    // Full game: P1 and P3 score 5, P0 scores 2
    repeat (5) begin
      pulse_ready(4'b1010);
      step(1);
    end
    pulse_ready(4'b0001);
    step(1);
    expect_eq("six_problem", 32'(problem),   32'd6);
    expect_eq("six_scores",  32'(scores),    32'h5051);
    expect_eq("six_over",    32'(game_over), 32'd0);
    expect_eq("six_winner",  32'(winner),    32'd0);
    pulse_ready(4'b0001);
    expect_eq("end_scores",  32'(scores),    32'h5052);
    expect_eq("end_problem", 32'(problem),   32'd7);
    expect_eq("end_state",   32'(state),     32'd2);
    expect_eq("end_over",    32'(game_over), 32'd1);
    expect_eq("end_winner",  32'(winner),    32'hA);
    expect_eq("end_reset",   32'(reset_o),   32'd1);
    step(1);
    expect_eq("end_reset_end", 32'(reset_o), 32'd0);

    // Extra ready edge after game over changes nothing
    pulse_ready(4'b1111);
    step(1);
    expect_eq("over_scores",  32'(scores),  32'h5052);
    expect_eq("over_problem", 32'(problem), 32'd7);
    expect_eq("over_state",   32'(state),   32'd2);
    expect_eq("over_reset",   32'(reset_o), 32'd0);
    expect_eq("over_winner",  32'(winner),  32'hA);

    // Saturation on the narrow instance (SCORE_W=2, POINTS=3)
    greset = 1'b1;
    step(1);
    greset = 1'b0;
    step(1);
    expect_eq("sat_play", 32'(state_s), 32'd1);
    check_s = 4'b0001;
    ready_s = 1'b1;
    step(1);
    ready_s = 1'b0;
    expect_eq("sat_first", 32'(scores_s), 32'h03);
    step(1);
    check_s = 4'b0011;
    ready_s = 1'b1;
    step(1);
    ready_s = 1'b0;
    expect_eq("sat_second",  32'(scores_s),  32'h0F);
    expect_eq("sat_problem", 32'(problem_s), 32'd2);
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
